// File: rtl/dma_reg_pkg.sv
// Shared definitions for the dma_modport register block: register offsets,
// field positions, engine state encoding and reset values.
package dma_reg_pkg;

  localparam logic [5:0] OFF_INTR         = 6'h00;
  localparam logic [5:0] OFF_CTRL         = 6'h04;
  localparam logic [5:0] OFF_IO_ADDR      = 6'h08;
  localparam logic [5:0] OFF_MEM_ADDR     = 6'h0C;
  localparam logic [5:0] OFF_EXTRA_INFO   = 6'h10;
  localparam logic [5:0] OFF_STATUS       = 6'h14;
  localparam logic [5:0] OFF_XFER_COUNT   = 6'h18;
  localparam logic [5:0] OFF_DESC_ADDR    = 6'h1C;
  localparam logic [5:0] OFF_ERROR_STATUS = 6'h20;
  localparam logic [5:0] OFF_CONFIG       = 6'h24;
  localparam logic [5:0] REG_SPAN         = 6'h28;

  localparam int unsigned CTRL_START_BIT       = 0;
  localparam int unsigned CTRL_WCOUNT_LSB      = 1;
  localparam int unsigned CTRL_WCOUNT_MSB      = 15;
  localparam int unsigned CTRL_IO_MEM_BIT      = 16;
  localparam int unsigned CFG_AUTO_RESTART_BIT = 2;
  localparam int unsigned INTR_DONE_BIT        = 0;
  localparam int unsigned ERR_ZERO_LEN_BIT     = 0;
  localparam int unsigned ERR_START_BUSY_BIT   = 1;
  localparam int unsigned ERR_MISALIGNED_BIT   = 2;

  localparam int unsigned WCOUNT_W = 15;
  localparam int unsigned ERR_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  localparam logic [31:0]         RST_WORD   = 32'h0000_0000;
  localparam logic [15:0]         RST_HALF   = 16'h0000;
  localparam logic [WCOUNT_W-1:0] RST_WCOUNT = 15'h0000;
  localparam logic [3:0]          RST_CFG    = 4'h0;
  localparam logic [ERR_W-1:0]    RST_ERR    = 3'b000;

  function automatic logic [31:0] status_word(input dma_state_e st, input logic busy,
                                              input logic done, input logic error);
    return {24'h00_0000, 2'b00, st, 1'b0, error, done, busy};
  endfunction

endpackage

// File: rtl/dma_xfer_engine.sv
// Transfer-count engine: IDLE -> BUSY -> DONE FSM with the TRANSFER_COUNT
// counter; the transfer length is latched when a transfer is accepted.
module dma_xfer_engine
  import dma_reg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WCOUNT_W-1:0] len,
  input  logic                auto_restart,
  output dma_state_e          state,
  output logic [31:0]         xfer_count,
  output logic                busy,
  output logic                done
);

  dma_state_e          state_r, state_next_s;
  logic [WCOUNT_W-1:0] len_r;
  logic [31:0]         count_r;
  logic                done_r;
  logic                start_ok_s, last_beat_s, enter_busy_s;

  // Acceptance and end-of-transfer qualifiers.
  always_comb begin
    start_ok_s   = start && (len != RST_WCOUNT);
    last_beat_s  = ((count_r + 32'd1) == {17'd0, len_r});
    enter_busy_s = (state_r != BUSY) && (state_next_s == BUSY);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_next_s;
  end

  // Next-state logic; a start outside IDLE is ignored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (start_ok_s)   state_next_s = BUSY; else state_next_s = IDLE;
      BUSY:    if (last_beat_s)  state_next_s = DONE; else state_next_s = BUSY;
      DONE:    if (auto_restart) state_next_s = BUSY; else state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Length latch, beat counter and sticky done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r   <= RST_WCOUNT;
      count_r <= RST_WORD;
      done_r  <= 1'b0;
    end else begin
      if ((state_r == IDLE) && start_ok_s) len_r <= len;
      else                                 len_r <= len_r;
      if (enter_busy_s)           count_r <= 32'd0;
      else if (state_r == BUSY)   count_r <= count_r + 32'd1;
      else                        count_r <= count_r;
      if (enter_busy_s)                                     done_r <= 1'b0;
      else if ((state_r == BUSY) && (state_next_s == DONE)) done_r <= 1'b1;
      else                                                  done_r <= done_r;
    end
  end

  // Outputs.
  always_comb begin
    state      = state_r;
    xfer_count = count_r;
    busy       = (state_r == BUSY);
    done       = done_r;
  end

endmodule

// File: rtl/dma_modport.sv
// DMA control/status register block: decode, register storage and read mux.
// Define DMA_ERROR_REG_EN to implement the sticky ERROR_STATUS register.
module dma_modport
  import dma_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [ADDR_WIDTH-1:0] off_s;
  logic [5:0]            reg_off_s;
  logic in_win_s, aligned_s, hit_s, wr_hit_s;
  logic wr_intr_s, wr_ctrl_s, wr_io_s, wr_mem_s, wr_extra_s, wr_desc_s, wr_cfg_s;
  logic start_req_s, done_evt_s, error_s;
  logic [15:0] intr_set_s, intr_clr_s;
  logic [31:0] status_s, err_word_s;

  logic [15:0]           intr_status_r, intr_mask_r;
  logic [WCOUNT_W-1:0]   w_count_r;
  logic                  io_mem_r;
  logic [DATA_WIDTH-1:0] io_addr_r, mem_addr_r, extra_info_r, desc_addr_r;
  logic [3:0]            cfg_r;

  dma_state_e  eng_state_s;
  logic [31:0] xfer_count_s;
  logic        eng_busy_s, eng_done_s;

  // Address decode; addresses below BASE_ADDR wrap high and fall outside the window.
  always_comb begin
    off_s      = addr - BASE_ADDR;
    in_win_s   = (off_s < {{(ADDR_WIDTH-6){1'b0}}, REG_SPAN});
    aligned_s  = (off_s[1:0] == 2'b00);
    hit_s      = in_win_s && aligned_s;
    reg_off_s  = off_s[5:0];
    wr_hit_s   = wr_en && hit_s;
    wr_intr_s  = wr_hit_s && (reg_off_s == OFF_INTR);
    wr_ctrl_s  = wr_hit_s && (reg_off_s == OFF_CTRL);
    wr_io_s    = wr_hit_s && (reg_off_s == OFF_IO_ADDR);
    wr_mem_s   = wr_hit_s && (reg_off_s == OFF_MEM_ADDR);
    wr_extra_s = wr_hit_s && (reg_off_s == OFF_EXTRA_INFO);
    wr_desc_s  = wr_hit_s && (reg_off_s == OFF_DESC_ADDR);
    wr_cfg_s   = wr_hit_s && (reg_off_s == OFF_CONFIG);
    start_req_s = wr_ctrl_s && wdata[CTRL_START_BIT];
  end

  dma_xfer_engine u_engine (
    .clk          (clk),
    .rst          (rst),
    .start        (start_req_s),
    .len          (wdata[CTRL_WCOUNT_MSB:CTRL_WCOUNT_LSB]),
    .auto_restart (cfg_r[CFG_AUTO_RESTART_BIT]),
    .state        (eng_state_s),
    .xfer_count   (xfer_count_s),
    .busy         (eng_busy_s),
    .done         (eng_done_s)
  );

  // Interrupt status set/clear terms; the hardware set dominates a same-cycle W1C.
  always_comb begin
    done_evt_s = (eng_state_s == DONE);
    intr_set_s = {15'd0, done_evt_s};
    if (wr_intr_s) intr_clr_s = wdata[15:0];
    else           intr_clr_s = 16'h0000;
  end

  // Interrupt status register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) intr_status_r <= RST_HALF;
    else      intr_status_r <= (intr_status_r & ~intr_clr_s) | intr_set_s;
  end

  // Plain read/write registers; start_dma is never stored so CTRL[0] reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intr_mask_r  <= RST_HALF;
      w_count_r    <= RST_WCOUNT;
      io_mem_r     <= 1'b0;
      io_addr_r    <= RST_WORD;
      mem_addr_r   <= RST_WORD;
      extra_info_r <= RST_WORD;
      desc_addr_r  <= RST_WORD;
      cfg_r        <= RST_CFG;
    end else begin
      if (wr_intr_s) intr_mask_r <= wdata[31:16];
      if (wr_ctrl_s) begin
        w_count_r <= wdata[CTRL_WCOUNT_MSB:CTRL_WCOUNT_LSB];
        io_mem_r  <= wdata[CTRL_IO_MEM_BIT];
      end
      if (wr_io_s)    io_addr_r    <= wdata;
      if (wr_mem_s)   mem_addr_r   <= wdata;
      if (wr_extra_s) extra_info_r <= wdata;
      if (wr_desc_s)  desc_addr_r  <= wdata;
      if (wr_cfg_s)   cfg_r        <= wdata[3:0];
    end
  end

`ifdef DMA_ERROR_REG_EN
  logic [ERR_W-1:0] err_r, err_set_s, err_clr_s;

  // Error event detection and W1C mask; any access to a misaligned in-window address counts.
  always_comb begin
    err_set_s = RST_ERR;
    err_set_s[ERR_ZERO_LEN_BIT]   = start_req_s && (eng_state_s == IDLE) &&
                                    (wdata[CTRL_WCOUNT_MSB:CTRL_WCOUNT_LSB] == RST_WCOUNT);
    err_set_s[ERR_START_BUSY_BIT] = start_req_s && (eng_state_s == BUSY);
    err_set_s[ERR_MISALIGNED_BIT] = (wr_en || rd_en) && in_win_s && !aligned_s;
    if (wr_hit_s && (reg_off_s == OFF_ERROR_STATUS)) err_clr_s = wdata[ERR_W-1:0];
    else                                             err_clr_s = RST_ERR;
    error_s    = |err_r;
    err_word_s = {29'd0, err_r};
  end

  // Sticky error register; a new event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_r <= RST_ERR;
    else      err_r <= (err_r & ~err_clr_s) | err_set_s;
  end
`else
  assign error_s    = 1'b0;
  assign err_word_s = RST_WORD;
`endif

  assign status_s = status_word(eng_state_s, eng_busy_s, eng_done_s, error_s);

  // Zero-wait read mux.
  always_comb begin
    rdata = {DATA_WIDTH{1'b0}};
    if (rd_en && hit_s) begin
      case (reg_off_s)
        OFF_INTR:         rdata = {intr_mask_r, intr_status_r};
        OFF_CTRL:         rdata = {15'd0, io_mem_r, w_count_r, 1'b0};
        OFF_IO_ADDR:      rdata = io_addr_r;
        OFF_MEM_ADDR:     rdata = mem_addr_r;
        OFF_EXTRA_INFO:   rdata = extra_info_r;
        OFF_STATUS:       rdata = status_s;
        OFF_XFER_COUNT:   rdata = xfer_count_s;
        OFF_DESC_ADDR:    rdata = desc_addr_r;
        OFF_ERROR_STATUS: rdata = err_word_s;
        OFF_CONFIG:       rdata = {28'd0, cfg_r};
        default:          rdata = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rdata = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_dma_modport.sv
// Self-checking bench for dma_modport: randomized bus traffic checked against
// a register-level model of the documented map and transfer rules.
module tb_dma_modport;

  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef DMA_ERROR_REG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] wdata = 32'h0, addr = 32'h0, rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of architecturally visible state.
  logic [31:0] m_io, m_mem, m_extra, m_desc, m_count;
  logic [15:0] m_mask, m_intr;
  logic [14:0] m_wcount;
  logic        m_iomem, m_done;
  logic [3:0]  m_cfg;
  logic [2:0]  m_err;

  dma_modport #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_io = 0; m_mem = 0; m_extra = 0; m_desc = 0; m_count = 0;
    m_mask = 0; m_intr = 0; m_wcount = 0; m_iomem = 0; m_done = 0;
    m_cfg = 0; m_err = 0;
  endfunction

  function automatic void note_access(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off < 32'h28 && off[1:0] != 2'b00) m_err = m_err | {ERR_EN, 2'b00};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    off = a - BASE;
    note_access(a);
    if (off < 32'h28 && off[1:0] == 2'b00) begin
      case (off[5:0])
        6'h00: begin m_mask = d[31:16]; m_intr = m_intr & ~d[15:0]; end
        6'h04: begin m_wcount = d[15:1]; m_iomem = d[16]; end
        6'h08: m_io = d;
        6'h0C: m_mem = d;
        6'h10: m_extra = d;
        6'h1C: m_desc = d;
        6'h20: m_err = m_err & ~d[2:0];
        6'h24: m_cfg = d[3:0];
        default: ;
      endcase
    end
  endfunction

  // Expected read value while the engine is idle.
  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!(off < 32'h28 && off[1:0] == 2'b00)) return 32'h0;
    case (off[5:0])
      6'h00: return {m_mask, m_intr};
      6'h04: return {15'd0, m_iomem, m_wcount, 1'b0};
      6'h08: return m_io;
      6'h0C: return m_mem;
      6'h10: return m_extra;
      6'h14: return {24'd0, 4'h0, 1'b0, |m_err, m_done, 1'b0};
      6'h18: return m_count;
      6'h1C: return m_desc;
      6'h20: return {29'd0, m_err};
      6'h24: return {28'd0, m_cfg};
      default: return 32'h0;
    endcase
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    #1 d = rdata;
    rd_en = 1'b0;
    note_access(a);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      bus_read(BASE + 32'(4 * i), rd);
      n_tests++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset[%0h]: got %h expected %h", BASE + 32'(4 * i), rd, 32'h0);
      end
    end
  endtask

  task automatic test_rw_random();
    logic [31:0] offs [7];
    logic [31:0] a, d, rd;
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h24};
    for (int i = 0; i < 24; i++) begin
      a = BASE + offs[$urandom_range(0, 6)];
      d = $urandom;
      if (a == BASE + 32'h04) d[0] = 1'b0;
      bus_write(a, d);
      bus_read(a, rd);
      n_tests++;
      if (rd !== exp_read(a)) begin
        n_fail++;
        $display("FAIL rw[%0h]: got %h expected %h", a, rd, exp_read(a));
      end
    end
    bus_write(BASE + 32'h08, 32'hA5A5_5A5A);
    bus_read(BASE + 32'h08, rd);
    n_tests++;
    if (rd !== 32'hA5A5_5A5A) begin
      n_fail++;
      $display("FAIL io_addr_pattern: got %h expected %h", rd, 32'hA5A5_5A5A);
    end
    bus_write(BASE + 32'h24, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h24, rd);
    n_tests++;
    if (rd !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL config_mask: got %h expected %h", rd, 32'h0000_000F);
    end
    bus_write(BASE + 32'h24, 32'h0000_0000);
  endtask

  task automatic test_rd_wr_same();
    logic [31:0] d, rd;
    d = $urandom;
    @(negedge clk);
    addr = BASE + 32'h0C; wdata = d; wr_en = 1'b1; rd_en = 1'b1;
    #1 rd = rdata;
    n_tests++;
    if (rd !== m_mem) begin
      n_fail++;
      $display("FAIL rdwr_prewrite: got %h expected %h", rd, m_mem);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    model_write(BASE + 32'h0C, d);
    bus_read(BASE + 32'h0C, rd);
    n_tests++;
    if (rd !== d) begin
      n_fail++;
      $display("FAIL rdwr_commit: got %h expected %h", rd, d);
    end
  endtask

  task automatic test_transfer();
    logic [31:0] rd, done_rd;
    int w, busy_cnt;
    for (int r = 0; r < 3; r++) begin
      w = $urandom_range(1, 8);
      bus_write(BASE + 32'h04, {15'd0, 1'($urandom_range(0, 1)), 15'(w), 1'b1});
      m_done = 1'b0;
      busy_cnt = 0;
      done_rd = 32'h0;
      for (int i = 0; i < 50; i++) begin
        bus_read(BASE + 32'h14, rd);
        if (rd[0]) busy_cnt++;
        else begin done_rd = rd; break; end
      end
      n_tests++;
      if (busy_cnt != w) begin
        n_fail++;
        $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, w);
      end
      n_tests++;
      if (done_rd !== {24'd0, 4'h2, 1'b0, |m_err, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL done_status: got %h expected %h", done_rd,
                 {24'd0, 4'h2, 1'b0, |m_err, 1'b1, 1'b0});
      end
      m_done = 1'b1; m_count = 32'(w); m_intr[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        logic [31:0] ra;
        ra = BASE + ((k == 0) ? 32'h18 : (k == 1) ? 32'h00 : (k == 2) ? 32'h04 : 32'h14);
        bus_read(ra, rd);
        n_tests++;
        if (rd !== exp_read(ra)) begin
          n_fail++;
          $display("FAIL xfer_post[%0h]: got %h expected %h", ra, rd, exp_read(ra));
        end
      end
      bus_write(BASE, {m_mask, 16'h0001});
      bus_read(BASE, rd);
      n_tests++;
      if (rd !== {m_mask, 16'h0000}) begin
        n_fail++;
        $display("FAIL intr_w1c: got %h expected %h", rd, {m_mask, 16'h0000});
      end
    end
  endtask

  task automatic test_busy_restart();
    logic [31:0] rd;
    int w, w2;
    bit idle_seen;
    w  = $urandom_range(12, 20);
    w2 = $urandom_range(1, 30);
    bus_write(BASE + 32'h04, {16'd0, 15'(w), 1'b1});
    m_done = 1'b0;
    bus_read(BASE + 32'h14, rd);
    bus_write(BASE + 32'h04, {16'd0, 15'(w2), 1'b1});
    m_err = m_err | {1'b0, ERR_EN, 1'b0};
    idle_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus_read(BASE + 32'h14, rd);
      if (!rd[0]) begin idle_seen = 1'b1; break; end
    end
    n_tests++;
    if (!idle_seen) begin
      n_fail++;
      $display("FAIL busy_restart_timeout: got busy expected idle within 60 cycles");
    end
    m_done = 1'b1; m_count = 32'(w); m_intr[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ra;
      ra = BASE + ((k == 0) ? 32'h18 : (k == 1) ? 32'h04 : (k == 2) ? 32'h14 : 32'h20);
      bus_read(ra, rd);
      n_tests++;
      if (rd !== exp_read(ra)) begin
        n_fail++;
        $display("FAIL busy_restart[%0h]: got %h expected %h", ra, rd, exp_read(ra));
      end
    end
    bus_write(BASE, {m_mask, 16'h0001});
    bus_write(BASE + 32'h20, 32'h7);
  endtask

  task automatic test_auto_restart();
    logic [31:0] rd;
    int w, busy_cnt;
    bit idle_seen;
    w = $urandom_range(2, 6);
    bus_write(BASE + 32'h24, {28'd0, m_cfg[3], 1'b1, m_cfg[1:0]});
    bus_write(BASE + 32'h04, {16'd0, 15'(w), 1'b1});
    busy_cnt = 0;
    for (int i = 0; i < 4 * (w + 1); i++) begin
      bus_read(BASE + 32'h14, rd);
      if (rd[0]) busy_cnt++;
    end
    n_tests++;
    if (busy_cnt != 4 * w) begin
      n_fail++;
      $display("FAIL auto_busy_count: got %0d expected %0d", busy_cnt, 4 * w);
    end
    bus_write(BASE + 32'h24, {28'd0, m_cfg[3], 1'b0, m_cfg[1:0]});
    idle_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus_read(BASE + 32'h14, rd);
      if (!rd[0] && rd[7:4] == 4'h0) begin idle_seen = 1'b1; break; end
    end
    n_tests++;
    if (!idle_seen) begin
      n_fail++;
      $display("FAIL auto_stop_timeout: got status %h expected idle within 40 cycles", rd);
    end
    m_done = 1'b1; m_count = 32'(w); m_intr[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] ra;
      ra = BASE + ((k == 0) ? 32'h18 : (k == 1) ? 32'h14 : 32'h00);
      bus_read(ra, rd);
      n_tests++;
      if (rd !== exp_read(ra)) begin
        n_fail++;
        $display("FAIL auto_post[%0h]: got %h expected %h", ra, rd, exp_read(ra));
      end
    end
    bus_write(BASE, {m_mask, 16'h0001});
  endtask

  task automatic test_unmapped_ro();
    logic [31:0] a, rd;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: a = 32'h0000_0500;
        1: a = BASE + 32'h14;
        2: a = BASE + 32'h18;
        3: a = BASE - 32'h4;
        4: a = BASE + 32'h28;
        5: a = BASE + 32'h28 + 32'($urandom_range(0, 40) * 4);
        default: a = BASE + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(1, 3));
      endcase
      bus_write(a, (i < 2) ? 32'h0000_1234 : $urandom);
      bus_read(a, rd);
      n_tests++;
      if (rd !== exp_read(a)) begin
        n_fail++;
        $display("FAIL unmapped_ro[%0h]: got %h expected %h", a, rd, exp_read(a));
      end
    end
    for (int i = 0; i < 10; i++) begin
      a = BASE + 32'(4 * i);
      bus_read(a, rd);
      n_tests++;
      if (rd !== exp_read(a)) begin
        n_fail++;
        $display("FAIL unmapped_sweep[%0h]: got %h expected %h", a, rd, exp_read(a));
      end
    end
    bus_write(BASE + 32'h20, 32'h7);
  endtask

  task automatic test_error_path();
    logic [31:0] rd;
    bus_write(BASE + 32'h04, 32'h0000_0001);
    m_err = m_err | {2'b00, ERR_EN};
    for (int k = 0; k < 2; k++) begin
      bus_read(BASE + ((k == 0) ? 32'h14 : 32'h20), rd);
      n_tests++;
      if (rd !== exp_read(BASE + ((k == 0) ? 32'h14 : 32'h20))) begin
        n_fail++;
        $display("FAIL zero_len[%0d]: got %h expected %h", k, rd,
                 exp_read(BASE + ((k == 0) ? 32'h14 : 32'h20)));
      end
    end
    bus_write(BASE + 32'h20, 32'h0000_0001);
    for (int k = 0; k < 2; k++) begin
      bus_read(BASE + ((k == 0) ? 32'h14 : 32'h20), rd);
      n_tests++;
      if (rd !== exp_read(BASE + ((k == 0) ? 32'h14 : 32'h20))) begin
        n_fail++;
        $display("FAIL err_clear[%0d]: got %h expected %h", k, rd,
                 exp_read(BASE + ((k == 0) ? 32'h14 : 32'h20)));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit hit10;
    bus_write(BASE + 32'h04, {16'd0, 15'd100, 1'b1});
    hit10 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus_read(BASE + 32'h18, rd);
      if (rd == 32'd10) begin hit10 = 1'b1; break; end
    end
    n_tests++;
    if (!hit10) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %h expected count 10 within 40 cycles", rd);
    end
    rst = 1'b0;
    #1;
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr = BASE + ((k == 0) ? 32'h14 : (k == 1) ? 32'h18 : 32'h04);
      #1 rd = rdata;
      n_tests++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_mid[%0h]: got %h expected %h", addr, rd, 32'h0);
      end
    end
    rd_en = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();
    bus_read(BASE + 32'h18, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got %h expected %h", rd, 32'h0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rw_random();
    test_rd_wr_same();
    test_transfer();
    test_busy_restart();
    test_auto_restart();
    test_unmapped_ro();
    test_error_path();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_modport.md
Name: dma_modport

Overview:
- Memory-mapped DMA control/status register block with a minimal transfer-count engine. Register maps as a UVM RAL model.
- Driven by a single-master bus: wdata, rdata, addr, wr_en, rd_en. Data and address widths come from the shared global parameters.
- Sits between the CPU/testbench bus agent and the DMA datapath. The datapath itself is out of scope; transfer progress is modelled internally.

Parameters:
- DATA_WIDTH, 32, bus data width (from `data_width).
- ADDR_WIDTH, 32, bus address width (from `addr_width).
- BASE_ADDR, 32'h400, address of the first register.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-low reset.
- wdata, input, DATA_WIDTH, write data.
- addr, input, ADDR_WIDTH, byte address, word aligned.
- wr_en, input, 1, write strobe; one write per cycle when high.
- rd_en, input, 1, read strobe.
- rdata, output, DATA_WIDTH, read data.

Behaviour:
Register map (offset from BASE_ADDR; reset values in brackets):
- 0x00 INTR: [15:0] intr_status, W1C, bit0 = done. [31:16] intr_mask, RW. [0]
- 0x04 CTRL: [0] start_dma, write-1 self-clears next cycle, reads 0. [15:1] w_count, RW. [16] io_mem, RW. [31:17] read 0. [0]
- 0x08 IO_ADDR, RW. [0]
- 0x0C MEM_ADDR, RW. [0]
- 0x10 EXTRA_INFO, RW. [0]
- 0x14 STATUS, RO: [0] busy, [1] done, [2] error, [3] paused (always 0), [7:4] state code (0 IDLE, 1 BUSY, 2 DONE). [0]
- 0x18 TRANSFER_COUNT, RO, 32-bit. [0]
- 0x1C DESCRIPTOR_ADDR, RW. [0]
- 0x20 ERROR_STATUS, W1C, see Optional Feature. [0]
- 0x24 CONFIG, RW: [1:0] priority, [2] auto_restart, [3] intr_en, [31:4] read 0. [0]

Bus rules:
- Read is combinational, zero wait: rdata = selected register while rd_en = 1, else 0.
- Write commits on the posedge where wr_en = 1.
- wr_en and rd_en together: rdata shows the pre-write value; the write commits at the edge.
- Unmapped or misaligned addresses read 0; writes to them are ignored.
- Writes to RO registers are ignored.
- All registers and rdata-related state return to reset values immediately on rst = 0.

Engine FSM (IDLE -> BUSY -> DONE -> IDLE):
- IDLE, start_dma written 1 with w_count != 0: TRANSFER_COUNT clears to 0, state -> BUSY, busy = 1.
- BUSY: TRANSFER_COUNT increments by 1 per cycle. When it equals w_count, state -> DONE.
- DONE: busy = 0, done = 1. intr_status[0] sets. Next cycle -> IDLE; done stays 1 until the next start.
- If CONFIG.auto_restart = 1, DONE goes to BUSY instead and TRANSFER_COUNT restarts from 0.
- start_dma written while BUSY is ignored.
- Changing CTRL.w_count while BUSY does not affect the running transfer; the length is latched at start.
- Reset mid-transfer aborts the transfer and returns to IDLE.
- Writing 1 to intr_status[0] in the same cycle it is set by hardware: hardware set wins.

Optional Feature:
- Macro DMA_ERROR_REG_EN.
- Defined:
  - ERROR_STATUS implemented: [0] zero_length_start, [1] start_while_busy, [2] misaligned_access.
  - Each bit is sticky and W1C.
  - STATUS.error = OR of the ERROR_STATUS bits.
  - A zero-length start sets bit0 and stays in IDLE.
- Undefined:
  - 0x20 reads 0, writes ignored.
  - STATUS.error is 0.
  - Zero-length start is silently ignored.

Decomposition:
- Package dma_reg_pkg holds:
  - register offset localparams;
  - field bit positions;
  - FSM state enum {IDLE, BUSY, DONE};
  - reset-value constants.
- One sub-module, dma_xfer_engine: the FSM and TRANSFER_COUNT. Register decode and read mux stay in the top.

Test Plan:
- Reset: after rst low then high, read 0x400..0x424 -> all 0 and STATUS = 0.
- RW sweep: write 32'hA5A5_5A5A to IO_ADDR (0x408) -> readback 32'hA5A5_5A5A. Write 0xFFFF_FFFF to CONFIG -> readback 32'h0000_000F.
- Transfer: write CTRL = (5<<1)|1.
  - Busy = 1 for 5 cycles; TRANSFER_COUNT reaches 5.
  - STATUS[1] = 1 and INTR[0] = 1.
  - CTRL[0] reads 0.
  - Write INTR = 1 -> INTR[0] clears.
- Unmapped and RO: write 0x1234 to 0x500 and to STATUS -> both read back unchanged (0 and current status).
- Reset mid-transfer: start w_count = 100, assert rst at count 10 -> STATUS = 0 and TRANSFER_COUNT = 0 immediately.
- DMA_ERROR_REG_EN: start with w_count = 0 -> ERROR_STATUS = 1, STATUS[2] = 1. Write 1 to 0x420 -> both clear.
